pool_reader_2: RTL and testbench

POOL_READER_2 -- requirements
Module: pool_reader_2

---
 rtl/pool_2_pkg.sv | 22 ++
 rtl/pool_rd_fifo_2.sv | 54 +++++
 rtl/pool_reader_2.sv | 186 ++++++++++++++++++
 tb/tb_pool_reader_2.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pool_2_pkg.sv
// Shared layer-2 pool parameters, plus the pool reader state encoding and FIFO sizing helper.
package pool_2_pkg;

  localparam int unsigned L2DataWidth     = 8;
  localparam int unsigned L2NumMult       = 16;
  localparam int unsigned L2PoolAddrWidth = 10;
  localparam int unsigned L2PoolDepth     = 1024;
  localparam int unsigned L2RdLatency     = 2;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRead  = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } pool_rd_state_e;

  // The in-flight reads plus two spare slots are what sustain one pair per cycle.
  function automatic int unsigned rd_fifo_depth(int unsigned rd_latency);
    return rd_latency + 2;
  endfunction

endpackage

// File: rtl/pool_rd_fifo_2.sv
// Small register-based FIFO for pool reader return data. It accepts a push together with a pop
// when it is full.
module pool_rd_fifo_2 #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned CNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 push,
  input  logic [WIDTH-1:0]     push_data,
  input  logic                 pop,
  output logic [WIDTH-1:0]     pop_data,
  output logic                 full,
  output logic                 empty,
  output logic [CNT_WIDTH-1:0] count
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign do_pop  = pop & (cnt_q != '0);
  assign do_push = push & ((cnt_q != CNT_WIDTH'(DEPTH)) | do_pop);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      cnt_q <= cnt_q + CNT_WIDTH'(do_push) - CNT_WIDTH'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign full     = (cnt_q == CNT_WIDTH'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign count    = cnt_q;

endmodule

// File: rtl/pool_reader_2.sv
// Streams the completed pool memory out as (even, odd) word pairs over a valid/ready handshake.
// Optional macro POOL_READER_STALL_CNT_EN adds a saturating 16-bit stall_cnt output.
module pool_reader_2
  import pool_2_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = L2DataWidth,
  parameter int unsigned NUM_MULT        = L2NumMult,
  parameter int unsigned POOL_ADDR_WIDTH = L2PoolAddrWidth,
  parameter int unsigned POOL_DEPTH      = L2PoolDepth,
  parameter int unsigned RD_LATENCY      = L2RdLatency
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           pool_done,
  input  logic [POOL_ADDR_WIDTH-1:0]     wr_address_a_t,
  input  logic [POOL_ADDR_WIDTH-1:0]     wr_address_b_t,
  input  logic                           wr_rden_a,
  input  logic                           wr_rden_b,
  input  logic                           wr_wren_a,
  input  logic                           wr_wren_b,
  output logic [POOL_ADDR_WIDTH-1:0]     address_a_t_use_out,
  output logic [POOL_ADDR_WIDTH-1:0]     address_b_t_use_out,
  output logic                           rden_a_use_out,
  output logic                           rden_b_use_out,
  output logic                           wren_a_use_out,
  output logic                           wren_b_use_out,
  input  logic [DATA_WIDTH*NUM_MULT-1:0] q_a_all_out,
  input  logic [DATA_WIDTH*NUM_MULT-1:0] q_b_all_out,
  output logic [DATA_WIDTH*NUM_MULT-1:0] rd_data_a,
  output logic [DATA_WIDTH*NUM_MULT-1:0] rd_data_b,
  output logic                           rd_valid,
  input  logic                           rd_ready,
  output logic                           rd_last,
  output logic                           busy,
  output logic                           read_done
`ifdef POOL_READER_STALL_CNT_EN
  ,
  output logic [15:0]                    stall_cnt
`endif
);

  localparam int unsigned BusW      = DATA_WIDTH * NUM_MULT;
  localparam int unsigned FifoDepth = rd_fifo_depth(RD_LATENCY);
  localparam int unsigned FifoW     = 2 * BusW + 1;
  localparam int unsigned CntW      = $clog2(FifoDepth + 1);
  localparam logic [POOL_ADDR_WIDTH-1:0] LastPtr = POOL_ADDR_WIDTH'(POOL_DEPTH - 2);

  pool_rd_state_e state_q, state_d;
  logic [POOL_ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic                       pool_done_q;
  logic [RD_LATENCY-1:0]      vld_sr_q, last_sr_q;
  logic                       pool_done_rise, issue, issue_last, push, pop;
  logic                       fifo_full, fifo_empty;
  logic [CntW-1:0]            fifo_cnt, outstanding;
  logic [CntW:0]              committed;
  logic [FifoW-1:0]           fifo_wdata, fifo_rdata;

  assign pool_done_rise = pool_done & ~pool_done_q;

  always_comb begin
    outstanding = '0;
    for (int i = 0; i < int'(RD_LATENCY); i++) begin
      outstanding = outstanding + CntW'(vld_sr_q[i]);
    end
  end

  // Reserve a FIFO slot for every read still in flight before issuing another.
  assign committed  = {1'b0, fifo_cnt} + {1'b0, outstanding};
  assign issue      = (state_q == StRead) && !fifo_full && (committed < (CntW + 1)'(FifoDepth));
  assign issue_last = issue && (rd_ptr_q == LastPtr);

  assign push       = vld_sr_q[RD_LATENCY-1];
  assign fifo_wdata = {last_sr_q[RD_LATENCY-1], q_b_all_out, q_a_all_out};

  assign rd_valid   = ~fifo_empty;
  assign pop        = rd_valid & rd_ready;
  assign rd_data_a  = fifo_rdata[BusW-1:0];
  assign rd_data_b  = fifo_rdata[2*BusW-1:BusW];
  assign rd_last    = fifo_rdata[2*BusW] & rd_valid;
  assign busy       = (state_q != StIdle);
  assign read_done  = (state_q == StDone);

  always_comb begin
    state_d             = state_q;
    rd_ptr_d            = rd_ptr_q;
    address_a_t_use_out = wr_address_a_t;
    address_b_t_use_out = wr_address_b_t;
    rden_a_use_out      = wr_rden_a;
    rden_b_use_out      = wr_rden_b;
    wren_a_use_out      = wr_wren_a;
    wren_b_use_out      = wr_wren_b;
    unique case (state_q)
      StIdle: begin
        if (pool_done_rise) begin
          state_d  = StRead;
          rd_ptr_d = '0;
        end
      end
      StRead: begin
        address_a_t_use_out = rd_ptr_q;
        address_b_t_use_out = rd_ptr_q + POOL_ADDR_WIDTH'(1);
        rden_a_use_out      = issue;
        rden_b_use_out      = issue;
        wren_a_use_out      = 1'b0;
        wren_b_use_out      = 1'b0;
        if (issue) begin
          rd_ptr_d = rd_ptr_q + POOL_ADDR_WIDTH'(2);
          if (issue_last) state_d = StDrain;
        end
      end
      StDrain: begin
        address_a_t_use_out = rd_ptr_q;
        address_b_t_use_out = rd_ptr_q + POOL_ADDR_WIDTH'(1);
        rden_a_use_out      = 1'b0;
        rden_b_use_out      = 1'b0;
        wren_a_use_out      = 1'b0;
        wren_b_use_out      = 1'b0;
        // The last-tagged pair is always the final FIFO entry.
        if (pop && rd_last) state_d = StDone;
      end
      StDone: begin
        rden_a_use_out = 1'b0;
        rden_b_use_out = 1'b0;
        wren_a_use_out = 1'b0;
        wren_b_use_out = 1'b0;
        state_d        = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      rd_ptr_q    <= '0;
      pool_done_q <= 1'b0;
      vld_sr_q    <= '0;
      last_sr_q   <= '0;
    end else begin
      state_q      <= state_d;
      rd_ptr_q     <= rd_ptr_d;
      pool_done_q  <= pool_done;
      vld_sr_q[0]  <= issue;
      last_sr_q[0] <= issue_last;
      for (int i = 1; i < int'(RD_LATENCY); i++) begin
        vld_sr_q[i]  <= vld_sr_q[i-1];
        last_sr_q[i] <= last_sr_q[i-1];
      end
    end
  end

  pool_rd_fifo_2 #(
    .WIDTH     (FifoW),
    .DEPTH     (FifoDepth),
    .CNT_WIDTH (CntW)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (fifo_wdata),
    .pop       (pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_cnt)
  );

`ifdef POOL_READER_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else if ((state_q == StIdle) && pool_done_rise) begin
      stall_cnt_q <= '0;
    end else if (rd_valid && !rd_ready && (stall_cnt_q != 16'hffff)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  // Stall counting is left out of this build.
`endif

endmodule

// File: tb/tb_pool_reader_2.sv
// Randomized bench for pool_reader_2 with a latency-accurate memory model and a pair-stream model.
module tb_pool_reader_2;

  localparam int unsigned DW    = 8;
  localparam int unsigned NM    = 2;
  localparam int unsigned AW    = 4;
  localparam int unsigned PD    = 8;
  localparam int unsigned LAT   = 2;
  localparam int unsigned BW    = DW * NM;
  localparam int          NPAIR = PD / 2;

  logic          clock = 1'b0;
  logic          reset;
  logic          pool_done;
  logic [AW-1:0] wr_address_a_t, wr_address_b_t;
  logic          wr_rden_a, wr_rden_b, wr_wren_a, wr_wren_b;
  logic [AW-1:0] address_a_t_use_out, address_b_t_use_out;
  logic          rden_a_use_out, rden_b_use_out, wren_a_use_out, wren_b_use_out;
  logic [BW-1:0] q_a_all_out, q_b_all_out, rd_data_a, rd_data_b;
  logic          rd_valid, rd_ready, rd_last, busy, read_done;

  pool_reader_2 #(
    .DATA_WIDTH      (DW),
    .NUM_MULT        (NM),
    .POOL_ADDR_WIDTH (AW),
    .POOL_DEPTH      (PD),
    .RD_LATENCY      (LAT)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .pool_done           (pool_done),
    .wr_address_a_t      (wr_address_a_t),
    .wr_address_b_t      (wr_address_b_t),
    .wr_rden_a           (wr_rden_a),
    .wr_rden_b           (wr_rden_b),
    .wr_wren_a           (wr_wren_a),
    .wr_wren_b           (wr_wren_b),
    .address_a_t_use_out (address_a_t_use_out),
    .address_b_t_use_out (address_b_t_use_out),
    .rden_a_use_out      (rden_a_use_out),
    .rden_b_use_out      (rden_b_use_out),
    .wren_a_use_out      (wren_a_use_out),
    .wren_b_use_out      (wren_b_use_out),
    .q_a_all_out         (q_a_all_out),
    .q_b_all_out         (q_b_all_out),
    .rd_data_a           (rd_data_a),
    .rd_data_b           (rd_data_b),
    .rd_valid            (rd_valid),
    .rd_ready            (rd_ready),
    .rd_last             (rd_last),
    .busy                (busy),
    .read_done           (read_done)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ready_mode = 0;
  int ph = 0;
  logic wr_fixed = 1'b0;

  logic [BW-1:0] mem [16];
  logic          hv [64];
  logic [AW-1:0] ha [64];
  logic [AW-1:0] hb [64];

  // Stream model
  logic    active = 1'b0;
  logic    prev_pd = 1'b0;
  logic    have_last = 1'b0;
  logic    ready_all = 1'b1;
  int      start_cyc = 0, exp_idx = 0, iss_idx = 0, last_cyc = 0;
  int      streams_started = 0, streams_done = 0, stream_len = 0;
  logic [AW-1:0] lit_a [4];
  logic [AW-1:0] lit_b [4];
  logic [AW-1:0] first_addr = '0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_passthrough();
    chk("pt_addr_a", address_a_t_use_out, wr_address_a_t);
    chk("pt_addr_b", address_b_t_use_out, wr_address_b_t);
    chk("pt_rden_a", rden_a_use_out, wr_rden_a);
    chk("pt_rden_b", rden_b_use_out, wr_rden_b);
    chk("pt_wren_a", wren_a_use_out, wr_wren_a);
    chk("pt_wren_b", wren_b_use_out, wr_wren_b);
  endtask

  // Pool memory: data for a read issued in cycle c is visible during cycle c+LAT, garbage otherwise.
  initial begin
    q_a_all_out = '0;
    q_b_all_out = '0;
    for (int i = 0; i < 64; i++) hv[i] = 1'b0;
    forever begin
      @(negedge clock);
      hv[cyc % 64] = rden_a_use_out;
      ha[cyc % 64] = address_a_t_use_out;
      hb[cyc % 64] = address_b_t_use_out;
      @(posedge clock);
      cyc++;
      #1;
      if (cyc >= int'(LAT) && hv[(cyc - int'(LAT)) % 64]) begin
        q_a_all_out = mem[ha[(cyc - int'(LAT)) % 64]];
        q_b_all_out = mem[hb[(cyc - int'(LAT)) % 64]];
      end else begin
        q_a_all_out = BW'($urandom);
        q_b_all_out = BW'($urandom);
      end
    end
  end

  // Ready pattern and writer-side traffic
  initial begin
    rd_ready = 1'b1;
    wr_address_a_t = '0; wr_address_b_t = '0;
    wr_rden_a = 1'b0; wr_rden_b = 1'b0; wr_wren_a = 1'b0; wr_wren_b = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      case (ready_mode)
        0: rd_ready = 1'b1;
        1: begin
          rd_ready = (ph % 4 == 0) || (ph % 4 == 3);
          ph++;
        end
        default: rd_ready = 1'($urandom_range(0, 1));
      endcase
      if (wr_fixed) begin
        wr_address_a_t = AW'(5); wr_address_b_t = AW'(9);
        wr_rden_a = 1'b0; wr_rden_b = 1'b0; wr_wren_a = 1'b1; wr_wren_b = 1'b0;
      end else begin
        wr_address_a_t = AW'($urandom); wr_address_b_t = AW'($urandom);
        wr_rden_a = 1'($urandom_range(0, 1)); wr_rden_b = 1'($urandom_range(0, 1));
        wr_wren_a = 1'($urandom_range(0, 1)); wr_wren_b = 1'($urandom_range(0, 1));
      end
    end
  end

  // Compare process
  always @(negedge clock) begin : cmp
    logic in_stream;
    if (!reset) begin
      active  = 1'b0;
      prev_pd = 1'b0;
      chk("rst_busy", busy, 0);
      chk("rst_valid", rd_valid, 0);
      chk("rst_done", read_done, 0);
      chk_passthrough();
    end else begin
      if (pool_done && !prev_pd && !active) begin
        active = 1'b1; start_cyc = cyc; exp_idx = 0; iss_idx = 0;
        have_last = 1'b0; ready_all = 1'b1; streams_started++;
      end
      prev_pd   = pool_done;
      in_stream = active && (cyc > start_cyc);
      chk("busy", busy, in_stream);
      if (!in_stream) begin
        chk_passthrough();
      end else begin
        chk("wren_a_read", wren_a_use_out, 0);
        chk("wren_b_read", wren_b_use_out, 0);
        chk("rden_pair", rden_b_use_out, rden_a_use_out);
        if (rden_a_use_out) begin
          chk("issue_extra", rden_a_use_out, iss_idx < NPAIR);
          chk("addr_a", address_a_t_use_out, 2 * iss_idx);
          chk("addr_b", address_b_t_use_out, 2 * iss_idx + 1);
          if (iss_idx == 0) first_addr = address_a_t_use_out;
          if (streams_started == 1 && iss_idx < 4) begin
            lit_a[iss_idx] = address_a_t_use_out;
            lit_b[iss_idx] = address_b_t_use_out;
          end
          iss_idx++;
        end
      end
      if (active && cyc == start_cyc + int'(LAT) + 1) chk("first_valid_early", rd_valid, 0);
      if (active && cyc == start_cyc + int'(LAT) + 2) chk("first_valid", rd_valid, 1);
      if (active) chk("read_done", read_done, have_last && (cyc == last_cyc + 1));
      else chk("read_done_idle", read_done, 0);
      if (rd_valid) begin
        if (!active || exp_idx >= NPAIR) begin
          chk("valid_extra", rd_valid, 0);
        end else begin
          chk("data_a", rd_data_a, mem[2 * exp_idx]);
          chk("data_b", rd_data_b, mem[2 * exp_idx + 1]);
          chk("last", rd_last, exp_idx == NPAIR - 1);
          if (!rd_ready) begin
            ready_all = 1'b0;
          end else begin
            exp_idx++;
            if (exp_idx == NPAIR) begin
              have_last = 1'b1;
              last_cyc  = cyc;
              if (ready_all) chk("throughput", cyc - start_cyc, int'(LAT) + 1 + NPAIR);
            end
          end
        end
      end
      if (active && have_last && cyc == last_cyc + 1) begin
        active     = 1'b0;
        stream_len = last_cyc - start_cyc;
        streams_done++;
      end
    end
  end

  task automatic start_stream();
    for (int i = 0; i < 16; i++) mem[i] = BW'($urandom);
    @(posedge clock); #1 pool_done = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1 pool_done = 1'b0;
  endtask

  task automatic wait_streams(input int target, input int budget);
    int n = 0;
    while (streams_done < target && n < budget) begin
      @(posedge clock);
      n++;
    end
    chk("stream_timeout", streams_done, target);
  endtask

  initial begin
    int target;
    int started_before;
    int n;
    reset = 1'b0;
    pool_done = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = BW'($urandom);
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    repeat (2) @(posedge clock);

    // Writer pass-through in IDLE
    wr_fixed = 1'b1;
    @(posedge clock); #2;
    chk("lit_wren_a", wren_a_use_out, 1);
    chk("lit_addr_a", address_a_t_use_out, 5);
    wr_fixed = 1'b0;

    // Full-rate stream
    ready_mode = 0;
    target = streams_done + 1;
    start_stream();
    wait_streams(target, 200);
    chk("lit_addr_a0", lit_a[0], 0);
    chk("lit_addr_b0", lit_b[0], 1);
    chk("lit_addr_a3", lit_a[3], 6);
    chk("lit_addr_b3", lit_b[3], 7);
    chk("lit_stream_len", stream_len, 7);
    chk("lit_xfers", exp_idx, 4);

    // 1,0,0,1 ready pattern
    ready_mode = 1;
    for (int s = 0; s < 2; s++) begin
      target = streams_done + 1;
      start_stream();
      wait_streams(target, 200);
    end

    // Random backpressure
    ready_mode = 2;
    for (int s = 0; s < 6; s++) begin
      repeat ($urandom_range(0, 3)) @(posedge clock);
      target = streams_done + 1;
      start_stream();
      wait_streams(target, 300);
    end

    // Reset at the second transfer, then restart
    ready_mode = 0;
    start_stream();
    n = 0;
    while (exp_idx < 2 && n < 100) begin
      @(negedge clock); #1;
      n++;
    end
    chk("reach_2nd_xfer", exp_idx, 2);
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1;
    chk("abort_busy", busy, 0);
    chk("abort_valid", rd_valid, 0);
    target = streams_done + 1;
    start_stream();
    wait_streams(target, 200);
    chk("restart_addr", first_addr, 0);
    chk("restart_xfers", exp_idx, 4);

    // Second pool_done rise during READ is ignored
    ready_mode = 0;
    started_before = streams_started;
    target = streams_done + 1;
    for (int i = 0; i < 16; i++) mem[i] = BW'($urandom);
    @(posedge clock); #1 pool_done = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1 pool_done = 1'b0;
    @(posedge clock); #1 pool_done = 1'b1;
    @(posedge clock); #1 pool_done = 1'b0;
    wait_streams(target, 200);
    repeat (4) @(posedge clock);
    #1;
    chk("no_restart", busy, 0);
    chk("single_stream", streams_started - started_before, 1);
    chk("second_rise_xfers", exp_idx, NPAIR);

    repeat (3) @(posedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
